// File: rtl/controle_jogo_pkg.sv
// rtl/controle_jogo_pkg.sv - shared types and limits for the game controller
// Contents: FSM state enum, selection limits, register widths.
package controle_jogo_pkg;

  typedef enum logic [2:0] {
    S_DESLIGADO  = 3'd0,
    S_PREPARACAO = 3'd1,
    S_ATQ_COL    = 3'd2,
    S_ATQ_LIN    = 3'd3,
    S_FIM        = 3'd4
  } estado_t;

  localparam int MAPA_MAX  = 3;
  localparam int COORD_MAX = 4;
  localparam int TIROS_W   = 4;
  localparam int COORD_W   = 3;

endpackage

// File: rtl/controle_jogo_detector_borda.sv
// rtl/controle_jogo_detector_borda.sv - button synchronizer, optional debounce, rising-edge pulse
// Optional feature: DEBOUNCE_EN (level filter between synchronizer and edge detector)
// Ports:
//   clock, reset_n : clock and asynchronous active-low reset
//   botao_i        : raw button, asynchronous to clock
//   pulso_o        : one-cycle pulse per accepted press
module detector_borda #(
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic botao_i,
  output logic pulso_o
);

  if (DEBOUNCE_CICLOS < 1) begin : g_cfg_invalida
    $error("DEBOUNCE_CICLOS must be at least 1");
  end

  logic sync1_q, sync2_q;
  // Tracks when sync2_q holds a real sample rather than its reset value.
  logic vld1_q, vld2_q;
  logic nivel;
  logic anterior_q;
  // Set only after a genuine low level is seen, so a button held through
  // reset release cannot generate a press.
  logic armado_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      vld1_q  <= 1'b0;
      vld2_q  <= 1'b0;
    end else begin
      sync1_q <= botao_i;
      sync2_q <= sync1_q;
      vld1_q  <= 1'b1;
      vld2_q  <= vld1_q;
    end
  end

`ifdef DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CICLOS + 1);
  logic [CNT_W-1:0] cnt_q;
  logic             filtro_q;

  // The filtered level follows sync2_q only after it has differed for
  // DEBOUNCE_CICLOS consecutive cycles; any bounce restarts the count.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q    <= '0;
      filtro_q <= 1'b0;
    end else if (sync2_q == filtro_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CICLOS - 1)) begin
      cnt_q    <= '0;
      filtro_q <= sync2_q;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign nivel = filtro_q;
`else
  assign nivel = sync2_q;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      anterior_q <= 1'b0;
      armado_q   <= 1'b0;
    end else begin
      anterior_q <= nivel;
      if (vld2_q && !sync2_q) begin
        armado_q <= 1'b1;
      end
    end
  end

  assign pulso_o = nivel & ~anterior_q & armado_q;

endmodule

// File: rtl/controle_jogo.sv
// rtl/controle_jogo.sv - game-mode FSM: power, map selection, shot entry, game over
// Optional feature: DEBOUNCE_EN (button debounce inside detector_borda)
// Ports:
//   clock, reset_n                 : clock and asynchronous active-low reset
//   botao_liga, botao_confirma     : raw buttons, asynchronous to clock
//   chaves[2:0]                    : switch value for map or coordinate entry
//   DESLIGADO, PREPARACAO, ATAQUE  : registered mode outputs, at most one high
//   mapa, coordColuna, coordLinha  : registered selections for the display
//   tiros[3:0]                     : shots remaining
//   tiro_valido                    : one-cycle pulse per completed shot
//   fim_jogo                       : high while the game is over
module controle_jogo
  import controle_jogo_pkg::*;
#(
  parameter int NUM_TIROS       = 10,
  parameter int DEBOUNCE_CICLOS = 16
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               botao_liga,
  input  logic               botao_confirma,
  input  logic [COORD_W-1:0] chaves,
  output logic               DESLIGADO,
  output logic               PREPARACAO,
  output logic               ATAQUE,
  output logic [COORD_W-1:0] mapa,
  output logic [COORD_W-1:0] coordColuna,
  output logic [COORD_W-1:0] coordLinha,
  output logic [TIROS_W-1:0] tiros,
  output logic               tiro_valido,
  output logic               fim_jogo
);

  if (NUM_TIROS < 1 || NUM_TIROS > 15) begin : g_cfg_invalida
    $error("NUM_TIROS must be in 1..15");
  end

  logic pulso_liga, pulso_conf;

  detector_borda #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_borda_liga (
    .clock   (clock),
    .reset_n (reset_n),
    .botao_i (botao_liga),
    .pulso_o (pulso_liga)
  );

  detector_borda #(.DEBOUNCE_CICLOS(DEBOUNCE_CICLOS)) u_borda_conf (
    .clock   (clock),
    .reset_n (reset_n),
    .botao_i (botao_confirma),
    .pulso_o (pulso_conf)
  );

  estado_t            estado_q, estado_d;
  logic [COORD_W-1:0] mapa_q, mapa_d, col_q, col_d, lin_q, lin_d;
  logic [TIROS_W-1:0] tiros_q, tiros_d;
  logic               valido_q, valido_d;
  logic               desl_q, desl_d, prep_q, prep_d, atq_q, atq_d, fim_q, fim_d;

  always_comb begin
    estado_d = estado_q;
    mapa_d   = mapa_q;
    col_d    = col_q;
    lin_d    = lin_q;
    tiros_d  = tiros_q;
    valido_d = 1'b0;

    // Power has priority: a simultaneous confirm is simply dropped.
    if (pulso_liga) begin
      estado_d = (estado_q == S_DESLIGADO) ? S_PREPARACAO : S_DESLIGADO;
    end else if (pulso_conf) begin
      case (estado_q)
        S_PREPARACAO: begin
          if (chaves <= COORD_W'(MAPA_MAX)) begin
            mapa_d   = chaves;
            tiros_d  = TIROS_W'(NUM_TIROS);
            estado_d = S_ATQ_COL;
          end
        end
        S_ATQ_COL: begin
          if (chaves <= COORD_W'(COORD_MAX)) begin
            col_d    = chaves;
            estado_d = S_ATQ_LIN;
          end
        end
        S_ATQ_LIN: begin
          if (chaves <= COORD_W'(COORD_MAX)) begin
            lin_d    = chaves;
            valido_d = 1'b1;
            tiros_d  = (tiros_q != '0) ? tiros_q - TIROS_W'(1) : '0;
            estado_d = (tiros_d == '0) ? S_FIM : S_ATQ_COL;
          end
        end
        S_FIM:   estado_d = S_PREPARACAO;
        default: estado_d = estado_q;
      endcase
    end

    // Mode flags are decoded from the next state so they register together
    // with the state itself.
    desl_d = (estado_d == S_DESLIGADO);
    prep_d = (estado_d == S_PREPARACAO);
    atq_d  = (estado_d == S_ATQ_COL) || (estado_d == S_ATQ_LIN);
    fim_d  = (estado_d == S_FIM);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= S_DESLIGADO;
      mapa_q   <= '0;
      col_q    <= '0;
      lin_q    <= '0;
      tiros_q  <= '0;
      valido_q <= 1'b0;
      desl_q   <= 1'b1;
      prep_q   <= 1'b0;
      atq_q    <= 1'b0;
      fim_q    <= 1'b0;
    end else begin
      estado_q <= estado_d;
      mapa_q   <= mapa_d;
      col_q    <= col_d;
      lin_q    <= lin_d;
      tiros_q  <= tiros_d;
      valido_q <= valido_d;
      desl_q   <= desl_d;
      prep_q   <= prep_d;
      atq_q    <= atq_d;
      fim_q    <= fim_d;
    end
  end

  assign DESLIGADO   = desl_q;
  assign PREPARACAO  = prep_q;
  assign ATAQUE      = atq_q;
  assign fim_jogo    = fim_q;
  assign mapa        = mapa_q;
  assign coordColuna = col_q;
  assign coordLinha  = lin_q;
  assign tiros       = tiros_q;
  assign tiro_valido = valido_q;

endmodule

// File: tb/tb_controle_jogo.sv
// tb/tb_controle_jogo.sv - self-checking bench for controle_jogo
module tb_controle_jogo;

`ifdef DEBOUNCE_EN
  localparam int HOLD   = 20;
  localparam int SETTLE = 22;
`else
  localparam int HOLD   = 3;
  localparam int SETTLE = 3;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       liga1, conf1, liga2, conf2;
  logic [2:0] chaves1, chaves2;

  logic       desl1, prep1, atq1, tv1, fim1;
  logic [2:0] mapa1, col1, lin1;
  logic [3:0] tiros1;
  logic       desl2, prep2, atq2, tv2, fim2;
  logic [2:0] mapa2, col2, lin2;
  logic [3:0] tiros2;

  logic [3:0] modo1, modo2;
  assign modo1 = {desl1, prep1, atq1, fim1};
  assign modo2 = {desl2, prep2, atq2, fim2};

  int n_checks = 0;
  int n_pass   = 0;

  // Expected {coordColuna, coordLinha, tiros} for each shot pulse.
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always #5 clock = ~clock;

  controle_jogo dut1 (
    .clock(clock), .reset_n(reset_n), .botao_liga(liga1), .botao_confirma(conf1),
    .chaves(chaves1), .DESLIGADO(desl1), .PREPARACAO(prep1), .ATAQUE(atq1),
    .mapa(mapa1), .coordColuna(col1), .coordLinha(lin1), .tiros(tiros1),
    .tiro_valido(tv1), .fim_jogo(fim1)
  );

  controle_jogo #(.NUM_TIROS(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .botao_liga(liga2), .botao_confirma(conf2),
    .chaves(chaves2), .DESLIGADO(desl2), .PREPARACAO(prep2), .ATAQUE(atq2),
    .mapa(mapa2), .coordColuna(col2), .coordLinha(lin2), .tiros(tiros2),
    .tiro_valido(tv2), .fim_jogo(fim2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic press(input int which, input bit liga, input bit conf, input logic [2:0] sw);
    @(posedge clock); #1;
    if (which == 1) begin chaves1 = sw; liga1 = liga; conf1 = conf; end
    else            begin chaves2 = sw; liga2 = liga; conf2 = conf; end
    repeat (HOLD) @(posedge clock);
    #1;
    if (which == 1) begin liga1 = 1'b0; conf1 = 1'b0; end
    else            begin liga2 = 1'b0; conf2 = 1'b0; end
    repeat (SETTLE) @(posedge clock);
    @(negedge clock);
  endtask

  always @(negedge clock) begin
    if (tv1 === 1'b1) begin
      check("tv1_expected_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) check("tv1_shot", {22'd0, col1, lin1, tiros1}, {22'd0, q1.pop_front()});
    end
    if (tv2 === 1'b1) begin
      check("tv2_expected_pending", 32'(q2.size() > 0), 32'd1);
      if (q2.size() > 0) check("tv2_shot", {22'd0, col2, lin2, tiros2}, {22'd0, q2.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    liga1 = 1'b0; conf1 = 1'b0; chaves1 = 3'd0;
    liga2 = 1'b0; conf2 = 1'b0; chaves2 = 3'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_modo", modo1, 4'b1000);
    check("rst_mapa", mapa1, 3'd0);
    check("rst_coords", {col1, lin1}, 6'd0);
    check("rst_tiros", tiros1, 4'd0);
    check("rst_tv", tv1, 1'b0);
    @(posedge clock); #1 reset_n = 1'b1;
    repeat (4) @(posedge clock);

`ifndef DEBOUNCE_EN
    @(posedge clock); #1 liga1 = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    check("lat_e2_modo", modo1, 4'b1000);
    @(posedge clock); #1;
    check("lat_e3_modo", modo1, 4'b0100);
    liga1 = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
`else
    press(1, 1'b1, 1'b0, 3'd0);
    check("liga_modo", modo1, 4'b0100);
`endif
    check("prep_mapa", mapa1, 3'd0);
    check("prep_tiros", tiros1, 4'd0);

    press(1, 1'b0, 1'b1, 3'd5);
    check("mapa5_ignored_modo", modo1, 4'b0100);
    check("mapa5_ignored_mapa", mapa1, 3'd0);
    press(1, 1'b0, 1'b1, 3'd2);
    check("mapa2_mapa", mapa1, 3'd2);
    check("mapa2_tiros", tiros1, 4'd10);
    check("mapa2_modo", modo1, 4'b0010);

    press(1, 1'b0, 1'b1, 3'd7);
    check("col7_ignored", col1, 3'd0);
    press(1, 1'b0, 1'b1, 3'd3);
    check("col3", col1, 3'd3);
    press(1, 1'b0, 1'b1, 3'd5);
    check("lin5_ignored", lin1, 3'd0);
    check("lin5_tiros", tiros1, 4'd10);
    q1.push_back({3'd3, 3'd4, 4'd9});
    press(1, 1'b0, 1'b1, 3'd4);
    check("shot1_lin", lin1, 3'd4);
    check("shot1_tiros", tiros1, 4'd9);
    check("shot1_modo", modo1, 4'b0010);

    press(1, 1'b0, 1'b1, 3'd1);
    press(1, 1'b1, 1'b1, 3'd2);
    check("ligaconf_modo", modo1, 4'b1000);
    check("ligaconf_tiros", tiros1, 4'd9);
    check("ligaconf_hold", {mapa1, col1, lin1}, {3'd2, 3'd1, 3'd4});
    press(1, 1'b1, 1'b0, 3'd0);
    check("religa_modo", modo1, 4'b0100);
    check("religa_mapa", mapa1, 3'd2);

    press(2, 1'b1, 1'b0, 3'd0);
    press(2, 1'b0, 1'b1, 3'd3);
    check("d2_mapa3", mapa2, 3'd3);
    check("d2_tiros", tiros2, 4'd2);
    press(2, 1'b0, 1'b1, 3'd4);
    q2.push_back({3'd4, 3'd0, 4'd1});
    press(2, 1'b0, 1'b1, 3'd0);
    check("d2_shot1_modo", modo2, 4'b0010);
    press(2, 1'b0, 1'b1, 3'd2);
    q2.push_back({3'd2, 3'd4, 4'd0});
    press(2, 1'b0, 1'b1, 3'd4);
    check("d2_fim_modo", modo2, 4'b0001);
    check("d2_fim_tiros", tiros2, 4'd0);
    press(2, 1'b0, 1'b1, 3'd7);
    check("d2_fim_conf_modo", modo2, 4'b0100);

    press(2, 1'b0, 1'b1, 3'd1);
    press(2, 1'b0, 1'b1, 3'd2);
    @(posedge clock); #1 chaves2 = 3'd3; conf2 = 1'b1;
    repeat (HOLD - 1) @(posedge clock);
    #4 reset_n = 1'b0;
    #1;
    check("abort_modo", modo2, 4'b1000);
    check("abort_tv", tv2, 1'b0);
    check("abort_regs", {mapa2, col2, lin2, tiros2}, 13'd0);
    conf2 = 1'b0;
    liga1 = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("held_reset_modo", modo1, 4'b1000);
    liga1 = 1'b0;
    repeat (30) @(posedge clock);
    press(1, 1'b1, 1'b0, 3'd0);
    check("after_release_modo", modo1, 4'b0100);

`ifdef DEBOUNCE_EN
    @(posedge clock); #1 liga1 = 1'b1;
    repeat (10) @(posedge clock);
    #1 liga1 = 1'b0;
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("glitch_modo", modo1, 4'b0100);
    press(1, 1'b1, 1'b0, 3'd0);
    repeat (30) @(posedge clock);
    @(negedge clock);
    check("long_press_modo", modo1, 4'b1000);
`endif

    check("q1_drained", q1.size(), 32'd0);
    check("q2_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/controle_jogo.md
CONTROLE_JOGO -- requirements
Module: controle_jogo

Interface
- REQ-001: Parameter NUM_TIROS, default 10, shots per game, legal range 1..15.
- REQ-002: Parameter DEBOUNCE_CICLOS, default 16, stable cycles a button needs before it is accepted; used only with DEBOUNCE_EN.
- REQ-003: Port clock, input, 1 bit, the single clock; all state changes on its rising edge.
- REQ-004: Port reset_n, input, 1 bit, asynchronous active-low reset.
- REQ-005: Port botao_liga, input, 1 bit, raw power button, active-high, asynchronous to clock.
- REQ-006: Port botao_confirma, input, 1 bit, raw confirm button, active-high, asynchronous to clock.
- REQ-007: Port chaves, input, 3 bits, switch value used for map or coordinate entry.
- REQ-008: Ports DESLIGADO, PREPARACAO, ATAQUE, outputs, 1 bit each, game mode, at most one high.
- REQ-009: Ports mapa, coordColuna, coordLinha, outputs, 3 bits each, registered values for the display stage.
- REQ-010: Port tiros, output, 4 bits, shots remaining.
- REQ-011: Port tiro_valido, output, 1 bit, one-cycle pulse per completed shot.
- REQ-012: Port fim_jogo, output, 1 bit, high while in state FIM.

Function
- REQ-013: Each button passes through a 2-flop synchronizer, then a rising-edge detector; one press yields exactly one internal pulse.
- REQ-014: Without DEBOUNCE_EN, outputs react at the 3rd rising clock edge after the raw button rises.
- REQ-015: FSM states are S_DESLIGADO, S_PREPARACAO, S_ATQ_COL, S_ATQ_LIN, S_FIM.
- REQ-016: Liga pulse in S_DESLIGADO -> S_PREPARACAO; liga pulse in any other state -> S_DESLIGADO.
- REQ-017: In S_PREPARACAO, confirm with chaves<=3 -> mapa<=chaves, tiros<=NUM_TIROS, next state S_ATQ_COL; with chaves>3 the confirm is ignored.
- REQ-018: In S_ATQ_COL, confirm with chaves<=4 -> coordColuna<=chaves, next state S_ATQ_LIN; with chaves>4 the confirm is ignored.
- REQ-019: In S_ATQ_LIN, confirm with chaves<=4 -> coordLinha<=chaves, tiro_valido=1 for 1 cycle, tiros-1; next state S_FIM if the new tiros is 0, else S_ATQ_COL; with chaves>4 the confirm is ignored.
- REQ-020: coordColuna and coordLinha are stable during the tiro_valido cycle.
- REQ-021: In S_FIM, confirm -> S_PREPARACAO.
- REQ-022: Mode outputs: DESLIGADO=1 only in S_DESLIGADO; PREPARACAO=1 only in S_PREPARACAO; ATAQUE=1 in S_ATQ_COL and S_ATQ_LIN; all three are 0 in S_FIM; all are registered.
- REQ-023: Liga and confirm pulses in the same cycle: liga wins and confirm is discarded.
- REQ-024: tiros never wraps below 0.
- REQ-025: mapa and the coordinate registers hold their values on entry to S_DESLIGADO.

Reset
- REQ-026: While reset_n=0: state S_DESLIGADO, DESLIGADO=1, all other outputs 0, synchronizer, edge and debounce flops cleared.
- REQ-027: A button held high through reset release produces no pulse.
- REQ-028: Reset asserted mid-game aborts immediately with no tiro_valido pulse.

Configuration
- REQ-029: With DEBOUNCE_EN defined, each synchronized button must remain at its new level for DEBOUNCE_CICLOS consecutive cycles before the filtered level changes; the edge detector acts on the filtered level.
- REQ-030: Without DEBOUNCE_EN, the edge detector acts directly on the synchronizer output and the debounce counter is absent.

Structure
- REQ-031: Shared package controle_jogo_pkg holds the FSM state enum, MAPA_MAX=3, COORD_MAX=4, and the widths of tiros and the coordinates.
- REQ-032: Sub-module detector_borda (synchronizer + optional debounce + edge detect) is instantiated once per button.

Verification
- REQ-033: Reset, then liga press -> PREPARACAO=1 at the 3rd edge after press (macro off); mapa=0, tiros=0.
- REQ-034: In PREPARACAO, chaves=5 plus confirm -> no change; chaves=2 plus confirm -> mapa=2, tiros=10, ATAQUE=1.
- REQ-035: Attack with col=3 then lin=4 -> coordColuna=3, coordLinha=4, one-cycle tiro_valido, tiros=9; col=7 is ignored.
- REQ-036: NUM_TIROS=2 with two full shots -> fim_jogo=1, ATAQUE=0, tiros=0; confirm -> PREPARACAO=1.
- REQ-037: Liga and confirm in the same cycle during S_ATQ_LIN -> DESLIGADO=1, no tiro_valido, tiros unchanged.
- REQ-038: With DEBOUNCE_EN, DEBOUNCE_CICLOS=16, a 10-cycle glitch -> no pulse; a 20-cycle press -> exactly one pulse.
